decode_bypass_stage: RTL and testbench

- Parametrised successor of the decode stage: decodes one RV instruction, reads operands and produces the execute-stage operand latch.
- Replaces the stall-on-any-match interlock with an N-source forwarding network and a ready-gated load-use interlock.
- Adds a valid/ready handshake toward EXE, a FLUSH input, XLEN generalisation (32/64) and a saturating stall counter.
- Sits between fetch and execute; the register file is external and reads combinationally.

---
 rtl/decode_bypass_stage.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_decode_bypass_stage.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_bypass_stage.sv
// Decode stage with an N-source operand forwarding network, a load-use
// interlock, a valid/ready handshake toward execute, flush, and a saturating
// stall counter. The register file is external and read combinationally.
module decode_bypass_stage #(
    parameter int XLEN  = 64,
    parameter int N_FWD = 3,
    parameter int CNT_W = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    DE_V,
    input  logic [XLEN-1:0]         DE_PC,
    input  logic [XLEN-1:0]         DE_NPC,
    input  logic [31:0]             DE_IR,
    output logic [4:0]              RS1_ADDR,
    output logic [4:0]              RS2_ADDR,
    input  logic [XLEN-1:0]         RS1_DATA,
    input  logic [XLEN-1:0]         RS2_DATA,
    input  logic [N_FWD-1:0]        FWD_V,
    input  logic [5*N_FWD-1:0]      FWD_DR,
    input  logic [N_FWD-1:0]        FWD_RDY,
    input  logic [XLEN*N_FWD-1:0]   FWD_DATA,
    input  logic                    EXE_READY,
    input  logic                    FLUSH,
    output logic                    DE_READY,
    output logic                    EXE_V,
    output logic [31:0]             EXE_IR,
    output logic [XLEN-1:0]         EXE_PC,
    output logic [XLEN-1:0]         EXE_NPC,
    output logic [4:0]              EXE_DR,
    output logic [XLEN-1:0]         ALU1,
    output logic [XLEN-1:0]         ALU2,
    output logic [XLEN-1:0]         TARGET_ADDRESS,
    output logic [XLEN-1:0]         MEM_ADDRESS,
    output logic                    ILLEGAL,
    output logic                    BR_STALL,
    output logic [CNT_W-1:0]        STALL_CNT
);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_IMM32  = 5'b00110;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_OP32   = 5'b01110;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    logic [4:0] opcode;
    logic [4:0] rs1_a;
    logic [4:0] rs2_a;
    logic [4:0] rd_a;
    logic [2:0] funct3;

    assign opcode   = DE_IR[6:2];
    assign rs1_a    = DE_IR[19:15];
    assign rs2_a    = DE_IR[24:20];
    assign rd_a     = DE_IR[11:7];
    assign funct3   = DE_IR[14:12];
    assign RS1_ADDR = rs1_a;
    assign RS2_ADDR = rs2_a;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_u;

    assign imm_i = XLEN'($signed(DE_IR[31:20]));
    assign imm_s = XLEN'($signed({DE_IR[31:25], DE_IR[11:7]}));
    assign imm_b = XLEN'($signed({DE_IR[31], DE_IR[7], DE_IR[30:25], DE_IR[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({DE_IR[31], DE_IR[19:12], DE_IR[20], DE_IR[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({DE_IR[31:12], 12'b0}));

    logic use1;
    logic use2;

    // Which register sources the current opcode actually reads
    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: use1 = 1'b1;
            OP_STORE, OP_OP, OP_OP32, OP_BRANCH: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] s1;
    logic [XLEN-1:0] s2;
    logic            hit1;
    logic            hit2;
    logic            pend1;
    logic            pend2;

    // Youngest matching forwarding source wins; its readiness alone decides the stall
    always_comb begin
        s1    = RS1_DATA;
        s2    = RS2_DATA;
        hit1  = 1'b0;
        hit2  = 1'b0;
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < N_FWD; i++) begin
            if (!hit1 && FWD_V[i] && (FWD_DR[5*i +: 5] == rs1_a)) begin
                hit1  = 1'b1;
                s1    = FWD_DATA[XLEN*i +: XLEN];
                pend1 = !FWD_RDY[i];
            end
            if (!hit2 && FWD_V[i] && (FWD_DR[5*i +: 5] == rs2_a)) begin
                hit2  = 1'b1;
                s2    = FWD_DATA[XLEN*i +: XLEN];
                pend2 = !FWD_RDY[i];
            end
        end
        if (rs1_a == 5'd0) begin
            s1    = '0;
            pend1 = 1'b0;
        end
        if (rs2_a == 5'd0) begin
            s2    = '0;
            pend2 = 1'b0;
        end
    end

    logic            hazard;
    logic            de_ready;
    logic            transfer;
    logic [XLEN-1:0] jalr_sum;

    assign hazard   = (use1 && pend1) || (use2 && pend2);
    assign de_ready = !hazard && (!EXE_V || EXE_READY);
    assign transfer = DE_V && de_ready && !FLUSH;
    assign jalr_sum = s1 + imm_i;

    logic [XLEN-1:0] dec_alu1;
    logic [XLEN-1:0] dec_alu2;
    logic [XLEN-1:0] dec_tgt;
    logic [XLEN-1:0] dec_mem;
    logic            dec_ill;
    logic [4:0]      dec_dr;

    // Operand formation for the instruction currently in decode
    always_comb begin
        dec_alu1 = '0;
        dec_alu2 = '0;
        dec_tgt  = '0;
        dec_mem  = '0;
        dec_ill  = (DE_IR[1:0] != 2'b11);
        case (opcode)
            OP_LOAD: dec_mem = s1 + imm_i;
            OP_IMM: begin
                dec_alu1 = s1;
                dec_alu2 = imm_i;
            end
            OP_STORE: begin
                dec_alu1 = s2;
                dec_mem  = s1 + imm_s;
            end
            OP_OP: begin
                dec_alu1 = s1;
                dec_alu2 = s2;
            end
            OP_IMM32: begin
                if (XLEN == 32) begin
                    dec_ill = 1'b1;
                end else begin
                    dec_alu1 = XLEN'($signed(s1[31:0]));
                    dec_alu2 = imm_i;
                end
            end
            OP_OP32: begin
                if (XLEN == 32) begin
                    dec_ill = 1'b1;
                end else begin
                    // SRLW shifts in zeros, so the upper half must not carry s1[31]
                    if (funct3 == 3'b101 && !DE_IR[30])
                        dec_alu1 = XLEN'(s1[31:0]);
                    else
                        dec_alu1 = XLEN'($signed(s1[31:0]));
                    dec_alu2 = XLEN'($signed(s2[31:0]));
                end
            end
            OP_BRANCH: begin
                dec_alu1 = s1;
                dec_alu2 = s2;
                dec_tgt  = DE_PC + imm_b;
            end
            OP_LUI, OP_AUIPC: dec_alu1 = imm_u;
            OP_JAL: begin
                dec_alu1 = DE_NPC;
                dec_tgt  = DE_PC + imm_j;
            end
            OP_JALR: begin
                dec_alu1 = DE_NPC;
                dec_tgt  = {jalr_sum[XLEN-1:1], 1'b0};
            end
            OP_SYSTEM: dec_alu1 = s1;
            default: dec_ill = 1'b1;
        endcase
    end

    // Destination register only for opcodes that write rd
    always_comb begin
        dec_dr = 5'd0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_IMM32, OP_OP, OP_OP32, OP_LUI, OP_AUIPC,
            OP_JAL, OP_JALR, OP_SYSTEM: dec_dr = rd_a;
            default: ;
        endcase
    end

    logic            exe_v_q,    exe_v_d;
    logic [31:0]     exe_ir_q,   exe_ir_d;
    logic [XLEN-1:0] exe_pc_q,   exe_pc_d;
    logic [XLEN-1:0] exe_npc_q,  exe_npc_d;
    logic [4:0]      exe_dr_q,   exe_dr_d;
    logic [XLEN-1:0] alu1_q,     alu1_d;
    logic [XLEN-1:0] alu2_q,     alu2_d;
    logic [XLEN-1:0] tgt_q,      tgt_d;
    logic [XLEN-1:0] mem_q,      mem_d;
    logic            illegal_q,  illegal_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Next-state for the execute latch and the stall counter
    always_comb begin
        exe_v_d     = exe_v_q;
        exe_ir_d    = exe_ir_q;
        exe_pc_d    = exe_pc_q;
        exe_npc_d   = exe_npc_q;
        exe_dr_d    = exe_dr_q;
        alu1_d      = alu1_q;
        alu2_d      = alu2_q;
        tgt_d       = tgt_q;
        mem_d       = mem_q;
        illegal_d   = illegal_q;
        stall_cnt_d = stall_cnt_q;

        if (FLUSH) begin
            exe_v_d = 1'b0;
        end else if (transfer) begin
            exe_v_d   = 1'b1;
            exe_ir_d  = DE_IR;
            exe_pc_d  = DE_PC;
            exe_npc_d = DE_NPC;
            exe_dr_d  = dec_dr;
            alu1_d    = dec_alu1;
            alu2_d    = dec_alu2;
            tgt_d     = dec_tgt;
            mem_d     = dec_mem;
            illegal_d = dec_ill;
        end else if (EXE_READY) begin
            exe_v_d = 1'b0;
        end

        if (DE_V && !de_ready && !FLUSH && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            exe_v_q     <= 1'b0;
            exe_ir_q    <= '0;
            exe_pc_q    <= '0;
            exe_npc_q   <= '0;
            exe_dr_q    <= '0;
            alu1_q      <= '0;
            alu2_q      <= '0;
            tgt_q       <= '0;
            mem_q       <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            exe_v_q     <= exe_v_d;
            exe_ir_q    <= exe_ir_d;
            exe_pc_q    <= exe_pc_d;
            exe_npc_q   <= exe_npc_d;
            exe_dr_q    <= exe_dr_d;
            alu1_q      <= alu1_d;
            alu2_q      <= alu2_d;
            tgt_q       <= tgt_d;
            mem_q       <= mem_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign DE_READY       = de_ready;
    assign BR_STALL       = DE_V && ((opcode == OP_BRANCH) || (opcode == OP_JALR) || (opcode == OP_JAL));
    assign EXE_V          = exe_v_q;
    assign EXE_IR         = exe_ir_q;
    assign EXE_PC         = exe_pc_q;
    assign EXE_NPC        = exe_npc_q;
    assign EXE_DR         = exe_dr_q;
    assign ALU1           = alu1_q;
    assign ALU2           = alu2_q;
    assign TARGET_ADDRESS = tgt_q;
    assign MEM_ADDRESS    = mem_q;
    assign ILLEGAL        = illegal_q;
    assign STALL_CNT      = stall_cnt_q;

endmodule

// File: tb/tb_decode_bypass_stage.sv
// Bench for decode_bypass_stage: a 64-bit instance checked every cycle
// against a behavioural model, plus a 32-bit instance with a 3-bit stall
// counter checked with hand-computed values.
module tb_decode_bypass_stage;

    logic         CLK = 1'b0;
    logic         RESET;
    always #5 CLK = ~CLK;

    // 64-bit instance
    logic         DE_V;
    logic [63:0]  DE_PC, DE_NPC;
    logic [31:0]  DE_IR;
    logic [4:0]   RS1_ADDR, RS2_ADDR;
    logic [63:0]  RS1_DATA, RS2_DATA;
    logic [2:0]   FWD_V, FWD_RDY;
    logic [14:0]  FWD_DR;
    logic [191:0] FWD_DATA;
    logic         EXE_READY, FLUSH, DE_READY, EXE_V, ILLEGAL, BR_STALL;
    logic [31:0]  EXE_IR;
    logic [63:0]  EXE_PC, EXE_NPC, ALU1, ALU2, TARGET_ADDRESS, MEM_ADDRESS;
    logic [4:0]   EXE_DR;
    logic [15:0]  STALL_CNT;

    decode_bypass_stage #(.XLEN(64), .N_FWD(3), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .DE_V(DE_V), .DE_PC(DE_PC), .DE_NPC(DE_NPC),
        .DE_IR(DE_IR), .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR),
        .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .FWD_V(FWD_V), .FWD_DR(FWD_DR),
        .FWD_RDY(FWD_RDY), .FWD_DATA(FWD_DATA), .EXE_READY(EXE_READY),
        .FLUSH(FLUSH), .DE_READY(DE_READY), .EXE_V(EXE_V), .EXE_IR(EXE_IR),
        .EXE_PC(EXE_PC), .EXE_NPC(EXE_NPC), .EXE_DR(EXE_DR), .ALU1(ALU1),
        .ALU2(ALU2), .TARGET_ADDRESS(TARGET_ADDRESS), .MEM_ADDRESS(MEM_ADDRESS),
        .ILLEGAL(ILLEGAL), .BR_STALL(BR_STALL), .STALL_CNT(STALL_CNT)
    );

    // 32-bit instance
    logic         b_de_v;
    logic [31:0]  b_pc, b_npc, b_ir;
    logic [4:0]   b_rs1_addr, b_rs2_addr;
    logic [31:0]  b_rs1_data, b_rs2_data;
    logic [1:0]   b_fwd_v, b_fwd_rdy;
    logic [9:0]   b_fwd_dr;
    logic [63:0]  b_fwd_data;
    logic         b_exe_ready, b_flush, b_de_ready, b_exe_v, b_illegal, b_br_stall;
    logic [31:0]  b_exe_ir, b_exe_pc, b_exe_npc, b_alu1, b_alu2, b_tgt, b_mem;
    logic [4:0]   b_exe_dr;
    logic [2:0]   b_stall_cnt;

    decode_bypass_stage #(.XLEN(32), .N_FWD(2), .CNT_W(3)) dut32 (
        .CLK(CLK), .RESET(RESET), .DE_V(b_de_v), .DE_PC(b_pc), .DE_NPC(b_npc),
        .DE_IR(b_ir), .RS1_ADDR(b_rs1_addr), .RS2_ADDR(b_rs2_addr),
        .RS1_DATA(b_rs1_data), .RS2_DATA(b_rs2_data), .FWD_V(b_fwd_v),
        .FWD_DR(b_fwd_dr), .FWD_RDY(b_fwd_rdy), .FWD_DATA(b_fwd_data),
        .EXE_READY(b_exe_ready), .FLUSH(b_flush), .DE_READY(b_de_ready),
        .EXE_V(b_exe_v), .EXE_IR(b_exe_ir), .EXE_PC(b_exe_pc), .EXE_NPC(b_exe_npc),
        .EXE_DR(b_exe_dr), .ALU1(b_alu1), .ALU2(b_alu2), .TARGET_ADDRESS(b_tgt),
        .MEM_ADDRESS(b_mem), .ILLEGAL(b_illegal), .BR_STALL(b_br_stall),
        .STALL_CNT(b_stall_cnt)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (64-bit instance) ----------------
    typedef struct packed {
        logic [63:0] a1, a2, tgt, mem;
        logic [4:0]  dr;
        logic        ill;
    } fields_t;

    bit          m_v;
    logic [31:0] m_ir;
    logic [63:0] m_pc, m_npc;
    fields_t     m_f;
    int          m_cnt;

    // Value and readiness seen by one source register
    function automatic void source(input logic [4:0] r, input logic [63:0] rf,
                                   output logic [63:0] v, output bit pend);
        v = rf;
        pend = 1'b0;
        if (r == 5'd0) begin
            v = 64'd0;
            return;
        end
        for (int i = 0; i < 3; i++)
            if (FWD_V[i] && FWD_DR[5*i +: 5] == r) begin
                v = FWD_DATA[64*i +: 64];
                pend = !FWD_RDY[i];
                return;
            end
    endfunction

    function automatic void eval(output bit hz, output logic [63:0] s1, output logic [63:0] s2);
        logic [4:0] op;
        bit p1, p2;
        op = DE_IR[6:2];
        source(DE_IR[19:15], RS1_DATA, s1, p1);
        source(DE_IR[24:20], RS2_DATA, s2, p2);
        hz = (p1 && (op inside {5'b00000, 5'b00100, 5'b00110, 5'b01000, 5'b01100,
                                5'b01110, 5'b11000, 5'b11001, 5'b11100}))
          || (p2 && (op inside {5'b01000, 5'b01100, 5'b01110, 5'b11000}));
    endfunction

    function automatic fields_t predict(input logic [31:0] ir, input logic [63:0] pc,
                                        input logic [63:0] npc, input logic [63:0] s1,
                                        input logic [63:0] s2);
        fields_t f;
        logic [63:0] ii, is_, ib, ij, iu;
        ii  = 64'($signed(ir[31:20]));
        is_ = 64'($signed({ir[31:25], ir[11:7]}));
        ib  = 64'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
        ij  = 64'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
        iu  = 64'($signed({ir[31:12], 12'b0}));
        f = '0;
        f.ill = (ir[1:0] != 2'b11);
        if (ir[6:2] inside {5'b00000, 5'b00100, 5'b00110, 5'b01100, 5'b01110, 5'b01101,
                            5'b00101, 5'b11011, 5'b11001, 5'b11100})
            f.dr = ir[11:7];
        case (ir[6:2])
            5'b00000: f.mem = s1 + ii;
            5'b00100: begin f.a1 = s1; f.a2 = ii; end
            5'b01000: begin f.a1 = s2; f.mem = s1 + is_; end
            5'b01100: begin f.a1 = s1; f.a2 = s2; end
            5'b00110: begin f.a1 = {{32{s1[31]}}, s1[31:0]}; f.a2 = ii; end
            5'b01110: begin
                f.a1 = (ir[14:12] == 3'b101 && !ir[30]) ? {32'd0, s1[31:0]}
                                                        : {{32{s1[31]}}, s1[31:0]};
                f.a2 = {{32{s2[31]}}, s2[31:0]};
            end
            5'b11000: begin f.a1 = s1; f.a2 = s2; f.tgt = pc + ib; end
            5'b01101, 5'b00101: f.a1 = iu;
            5'b11011: begin f.a1 = npc; f.tgt = pc + ij; end
            5'b11001: begin f.a1 = npc; f.tgt = (s1 + ii) & ~64'd1; end
            5'b11100: f.a1 = s1;
            default: f.ill = 1'b1;
        endcase
        return f;
    endfunction

    // Model advances on each rising edge using the inputs held over the cycle
    always @(posedge CLK) begin
        bit hz, rdy, xfer;
        logic [63:0] s1, s2;
        if (RESET) begin
            m_v = 1'b0; m_ir = '0; m_pc = '0; m_npc = '0; m_f = '0; m_cnt = 0;
        end else begin
            eval(hz, s1, s2);
            rdy  = !hz && (!m_v || EXE_READY);
            xfer = DE_V && rdy && !FLUSH;
            if (DE_V && !rdy && !FLUSH && m_cnt < 65535) m_cnt++;
            if (FLUSH) m_v = 1'b0;
            else if (xfer) begin
                m_v = 1'b1; m_ir = DE_IR; m_pc = DE_PC; m_npc = DE_NPC;
                m_f = predict(DE_IR, DE_PC, DE_NPC, s1, s2);
            end else if (EXE_READY) m_v = 1'b0;
        end
    end

    // Compare DUT against the model in the middle of every cycle
    always @(negedge CLK) begin
        bit hz;
        logic [63:0] s1, s2;
        if (chk_en && !RESET) begin
            eval(hz, s1, s2);
            chk("m_de_ready", DE_READY, !hz && (!m_v || EXE_READY));
            chk("m_br_stall", BR_STALL, DE_V && (DE_IR[6:2] inside {5'b11000, 5'b11001, 5'b11011}));
            chk("m_rs1_addr", RS1_ADDR, DE_IR[19:15]);
            chk("m_rs2_addr", RS2_ADDR, DE_IR[24:20]);
            chk("m_exe_v", EXE_V, m_v);
            chk("m_stall_cnt", STALL_CNT, m_cnt);
            if (m_v) begin
                chk("m_exe_ir", EXE_IR, m_ir);
                chk("m_exe_pc", EXE_PC, m_pc);
                chk("m_exe_npc", EXE_NPC, m_npc);
                chk("m_exe_dr", EXE_DR, m_f.dr);
                chk("m_alu1", ALU1, m_f.a1);
                chk("m_alu2", ALU2, m_f.a2);
                chk("m_target", TARGET_ADDRESS, m_f.tgt);
                chk("m_mem", MEM_ADDRESS, m_f.mem);
                chk("m_illegal", ILLEGAL, m_f.ill);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [31:0] ir, input logic [63:0] pc);
        DE_V = 1'b1; DE_IR = ir; DE_PC = pc; DE_NPC = pc + 64'd4;
    endtask

    task automatic set_fwd(input logic [2:0] v, input logic [14:0] dr,
                           input logic [2:0] rdy, input logic [191:0] data);
        FWD_V = v; FWD_DR = dr; FWD_RDY = rdy; FWD_DATA = data;
    endtask

    logic [31:0] vec_ir [12] = '{32'h00532423, 32'hFE528EE3, 32'h008000EF, 32'h002180E7,
                                 32'h405353BB, 32'hFFF3039B, 32'hFF833383, 32'h80000297,
                                 32'h00030073, 32'h0000000B, 32'h00A5F5B3, 32'h800002B7};

    initial begin
        RESET = 1'b1; DE_V = 0; DE_IR = 0; DE_PC = 0; DE_NPC = 0;
        RS1_DATA = 0; RS2_DATA = 0; EXE_READY = 1; FLUSH = 0;
        set_fwd(3'b000, 15'd0, 3'b000, 192'd0);
        b_de_v = 0; b_pc = 0; b_npc = 0; b_ir = 0; b_rs1_data = 0; b_rs2_data = 0;
        b_fwd_v = 0; b_fwd_rdy = 0; b_fwd_dr = 0; b_fwd_data = 0; b_exe_ready = 1; b_flush = 0;
        repeat (2) tick();
        chk("rst_exe_v", EXE_V, 0);
        chk("rst_stall_cnt", STALL_CNT, 0);
        chk("rst_illegal", ILLEGAL, 0);
        chk("rst_alu1", ALU1, 0);
        chk("rst32_exe_v", b_exe_v, 0);
        RESET = 1'b0;
        chk_en = 1'b1;

        // Back-to-back dependency through source 0
        RS1_DATA = 64'hDEAD; RS2_DATA = 64'hBEEF;
        issue(32'h00700293, 64'h1000);           // ADDI x5,x0,7
        tick();
        issue(32'h00528333, 64'h1004);           // ADD x6,x5,x5
        set_fwd(3'b001, {5'd0, 5'd0, 5'd5}, 3'b001, {64'd0, 64'd0, 64'd7});
        #1 chk("b2b_de_ready", DE_READY, 1);
        tick();
        chk("b2b_alu1", ALU1, 7);
        chk("b2b_alu2", ALU2, 7);
        chk("b2b_exe_dr", EXE_DR, 6);

        // Load-use: young unready match must not be masked by an older ready one
        issue(32'h00528333, 64'h1008);
        set_fwd(3'b101, {5'd5, 5'd0, 5'd5}, 3'b100, {64'd3, 64'd0, 64'h55});
        #1 chk("lu_de_ready0", DE_READY, 0);
        tick();
        #1 chk("lu_de_ready1", DE_READY, 0);
        tick();
        FWD_RDY = 3'b101;
        #1 chk("lu_de_ready2", DE_READY, 1);
        chk("lu_stall_cnt", STALL_CNT, 2);
        tick();
        chk("lu_alu1", ALU1, 64'h55);
        chk("lu_alu2", ALU2, 64'h55);

        // LUI: unused rs1 field matches an unready source, x0 match unready too
        issue(32'h123450B7, 64'h100C);           // LUI x1,0x12345 (rs1 field = 8)
        set_fwd(3'b011, {5'd0, 5'd8, 5'd0}, 3'b000, 192'd0);
        #1 chk("lui_de_ready", DE_READY, 1);
        tick();
        chk("lui_alu1", ALU1, 64'h12345000);
        chk("lui_alu2", ALU2, 0);
        set_fwd(3'b000, 15'd0, 3'b000, 192'd0);

        // Backpressure for three cycles
        EXE_READY = 0; RS1_DATA = 64'd100;
        issue(32'h00508393, 64'h1010);           // ADDI x7,x1,5
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_de_ready", DE_READY, 0);
            tick();
            chk("bp_exe_v", EXE_V, 1);
            chk("bp_alu1_hold", ALU1, 64'h12345000);
        end
        EXE_READY = 1;
        #1 chk("bp_release", DE_READY, 1);
        chk("bp_stall_cnt", STALL_CNT, 5);
        tick();
        chk("bp_alu1", ALU1, 100);
        chk("bp_alu2", ALU2, 5);

        // Flush while held: latch drops, no transfer, no stall count
        EXE_READY = 0; FLUSH = 1;
        issue(32'h00528333, 64'h1014);
        tick();
        FLUSH = 0;
        chk("fl_exe_v", EXE_V, 0);
        chk("fl_alu1_hold", ALU1, 100);
        chk("fl_stall_cnt", STALL_CNT, 5);
        EXE_READY = 1;
        tick();

        // Opcode sweep checked by the model, with bubbles between
        for (int i = 0; i < 12; i++) begin
            RS1_DATA = 64'hF0F0_0000_8000_1234 + 64'(i);
            RS2_DATA = 64'h0000_0001_7FFF_FFF0 - 64'(i);
            issue(vec_ir[i], 64'h2000 + 64'(16 * i));
            tick();
            if (i % 2 == 1) begin
                DE_V = 0;
                tick();
            end
        end

        // SRLW zero-extends rs1, sign-extends rs2
        RS1_DATA = 64'hFFFF_FFFF_8000_0000; RS2_DATA = 64'h0000_0000_8000_0004;
        issue(32'h005353BB, 64'h3000);
        tick();
        chk("srlw_alu1", ALU1, 64'h0000_0000_8000_0000);
        chk("srlw_alu2", ALU2, 64'hFFFF_FFFF_8000_0004);

        // x0 never forwards
        RS1_DATA = 64'h77; RS2_DATA = 64'h44;
        set_fwd(3'b001, {5'd0, 5'd0, 5'd0}, 3'b001, {64'd0, 64'd0, 64'h99});
        issue(32'h00500333, 64'h3004);           // ADD x6,x0,x5
        tick();
        chk("x0_alu1", ALU1, 0);
        chk("x0_alu2", ALU2, 64'h44);

        // Two matching sources: lower index wins
        RS1_DATA = 64'h777; RS2_DATA = 64'h55;
        set_fwd(3'b110, {5'd6, 5'd6, 5'd0}, 3'b111, {64'h222, 64'h111, 64'd0});
        issue(32'h00532423, 64'h3008);           // SW x5,8(x6)
        tick();
        chk("prio_mem", MEM_ADDRESS, 64'h119);
        chk("prio_alu1", ALU1, 64'h55);
        set_fwd(3'b000, 15'd0, 3'b000, 192'd0);

        // JALR on 64-bit
        RS1_DATA = 64'h1001;
        issue(32'h002180E7, 64'h3000);           // JALR x1,2(x3)
        tick();
        chk("jalr64_tgt", TARGET_ADDRESS, 64'h1002);
        chk("jalr64_alu1", ALU1, 64'h3004);
        chk("jalr64_dr", EXE_DR, 1);

        // Reset in the middle of a load-use stall
        set_fwd(3'b001, {5'd0, 5'd0, 5'd5}, 3'b000, 192'd0);
        issue(32'h00528333, 64'h4000);
        tick(); tick();
        RESET = 1;
        tick();
        chk("rst_mid_exe_v", EXE_V, 0);
        chk("rst_mid_stall_cnt", STALL_CNT, 0);
        RESET = 0;
        DE_V = 0;
        set_fwd(3'b000, 15'd0, 3'b000, 192'd0);
        tick();

        // 32-bit build
        b_de_v = 1; b_ir = 32'h005303BB; b_pc = 32'h100; b_npc = 32'h104;   // ADDW x7,x6,x5
        b_rs1_data = 32'h5; b_rs2_data = 32'h6;
        tick();
        chk("x32_addw_ill", b_illegal, 1);
        chk("x32_addw_alu1", b_alu1, 0);
        chk("x32_addw_alu2", b_alu2, 0);
        chk("x32_addw_v", b_exe_v, 1);
        b_ir = 32'h002180E7; b_pc = 32'h2000; b_npc = 32'h2004; b_rs1_data = 32'h1001;
        tick();
        chk("x32_jalr_tgt", b_tgt, 32'h1002);
        chk("x32_jalr_alu1", b_alu1, 32'h2004);
        chk("x32_jalr_ill", b_illegal, 0);

        // 3-bit counter saturates at 7
        b_ir = 32'h00528333; b_fwd_v = 2'b01; b_fwd_dr = {5'd0, 5'd5}; b_fwd_rdy = 2'b00;
        repeat (9) tick();
        chk("x32_stall_sat", b_stall_cnt, 7);
        chk("x32_stall_ready", b_de_ready, 0);
        b_de_v = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
